// File: rtl/gold_scrambler.sv
// CCSDS Gold-sequence I/Q scrambler: seeks the x generator to code n, then
// rotates each accepted symbol by R_n(i) and restarts the sequence every frame.
module gold_scrambler #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [17:0]       i_code,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_i,
    input  logic [DATA_W-1:0] i_q,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_i,
    output logic [DATA_W-1:0] o_q,
    output logic [1:0]        o_r,
    output logic              o_sof,
    output logic              o_busy
);

    localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FRAME_LEN - 1);
    localparam logic [17:0]       X_INIT  = 18'd1;
    localparam logic [17:0]       Y_INIT  = '1;
    localparam logic [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_ONE   = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [17:0]       r_x;
    logic [17:0]       r_y;
    logic [17:0]       r_xSeed;
    logic [17:0]       r_cnt;
    logic [FC_W-1:0]   r_fc;
    logic              r_oValid;
    logic [DATA_W-1:0] r_oI;
    logic [DATA_W-1:0] r_oQ;
    logic [1:0]        r_oR;
    logic              r_oSof;

    logic              w_ready;
    logic              w_busy;
    logic              w_accept;
    logic              w_z1;
    logic              w_z2;
    logic [1:0]        w_r;
    logic [DATA_W-1:0] w_rotI;
    logic [DATA_W-1:0] w_rotQ;

    function automatic logic [17:0] stepX(input logic [17:0] v);
        return {v[7] ^ v[0], v[17:1]};
    endfunction

    function automatic logic [17:0] stepY(input logic [17:0] v);
        return {v[10] ^ v[7] ^ v[5] ^ v[0], v[17:1]};
    endfunction

    // The most negative sample has no positive twin, so it clips to full scale.
    function automatic logic [DATA_W-1:0] satNeg(input logic [DATA_W-1:0] v);
        return (v == S_MIN) ? S_MAX : (~v + S_ONE);
    endfunction

    // y7 is not a tap of the half-period-shifted y term.
    assign w_z1 = r_x[4] ^ r_x[6] ^ r_x[15];
    assign w_z2 = ^{r_y[15:8], r_y[6:5]};
    assign w_r  = {w_z1 ^ w_z2, r_x[0] ^ r_y[0]};

    always_comb begin
        w_rotI = i_i;
        w_rotQ = i_q;
        case (w_r)
            2'd1: begin
                w_rotI = satNeg(i_q);
                w_rotQ = i_i;
            end
            2'd2: begin
                w_rotI = satNeg(i_i);
                w_rotQ = satNeg(i_q);
            end
            2'd3: begin
                w_rotI = i_q;
                w_rotQ = satNeg(i_i);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_SEEK: begin
                w_busy = 1'b1;
                if (r_cnt == 18'd0) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = (!r_oValid || i_ready) && !i_start;
            end
            default: w_nextState = ST_IDLE;
        endcase
        if (i_start) begin
            w_nextState = ST_SEEK;
        end
    end

    assign w_accept = w_ready && i_valid;

    // A start pulse overrides everything, including a symbol offered the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x      <= X_INIT;
            r_y      <= Y_INIT;
            r_xSeed  <= X_INIT;
            r_cnt    <= 18'd0;
            r_fc     <= '0;
            r_oValid <= 1'b0;
            r_oI     <= '0;
            r_oQ     <= '0;
            r_oR     <= 2'd0;
            r_oSof   <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= i_code;
            r_x      <= X_INIT;
            r_y      <= Y_INIT;
            r_fc     <= '0;
            r_oValid <= 1'b0;
        end else begin
            if (r_state == ST_SEEK) begin
                if (r_cnt != 18'd0) begin
                    r_x   <= stepX(r_x);
                    r_cnt <= r_cnt - 18'd1;
                end else begin
                    r_xSeed <= r_x;
                    r_fc    <= '0;
                end
            end
            if (w_accept) begin
                r_oValid <= 1'b1;
                r_oI     <= w_rotI;
                r_oQ     <= w_rotQ;
                r_oR     <= w_r;
                r_oSof   <= (r_fc == '0);
                if (r_fc == FC_LAST) begin
                    r_x  <= r_xSeed;
                    r_y  <= Y_INIT;
                    r_fc <= '0;
                end else begin
                    r_x  <= stepX(r_x);
                    r_y  <= stepY(r_y);
                    r_fc <= r_fc + FC_W'(1);
                end
            end else if (i_ready) begin
                r_oValid <= 1'b0;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_busy  = w_busy;
    assign o_valid = r_oValid;
    assign o_i     = r_oI;
    assign o_q     = r_oQ;
    assign o_r     = r_oR;
    assign o_sof   = r_oSof;

endmodule

// File: tb/tb_gold_scrambler.sv
// Scoreboard bench for gold_scrambler: stimulus pushes expected symbols from a
// sequence-level Gold model, a monitor pops and compares on each output handshake.
module tb_gold_scrambler;

    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = 4;
    localparam int MAXV      = 127;
    localparam int MODEL_LEN = 1024;

    logic                     i_clk   = 1'b0;
    logic                     i_reset = 1'b1;
    logic                     i_start = 1'b0;
    logic [17:0]              i_code  = '0;
    logic                     i_valid = 1'b0;
    logic                     o_ready;
    logic signed [DATA_W-1:0] i_i     = '0;
    logic signed [DATA_W-1:0] i_q     = '0;
    logic                     o_valid;
    logic                     i_ready = 1'b0;
    logic [DATA_W-1:0]        o_i;
    logic [DATA_W-1:0]        o_q;
    logic [1:0]               o_r;
    logic                     o_sof;
    logic                     o_busy;

    gold_scrambler #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_code  (i_code),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_i     (i_i),
        .i_q     (i_q),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_i     (o_i),
        .o_q     (o_q),
        .o_r     (o_r),
        .o_sof   (o_sof),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int       ei;
        int       eq;
        logic [1:0] r;
        logic     sof;
    } exp_t;

    exp_t       expQ[$];
    logic [1:0] obsR[$];
    logic       obsSof[$];
    int         obsI[$];
    int         obsQ[$];
    int         vectors     = 0;
    int         miscompares = 0;
    bit         xb[MODEL_LEN];
    bit         yb[MODEL_LEN];
    int         curCode = 0;
    int         symIdx  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // R from the two m-sequences: symbol k of code n sees x advanced by n+k, y by k.
    function automatic logic [1:0] modelR(input int n, input int k);
        int  s;
        bit  lsb;
        bit  msb;
        s   = n + k;
        lsb = xb[s] ^ yb[k];
        msb = xb[s+4] ^ xb[s+6] ^ xb[s+15]
            ^ yb[k+5] ^ yb[k+6] ^ yb[k+8] ^ yb[k+9] ^ yb[k+10]
            ^ yb[k+11] ^ yb[k+12] ^ yb[k+13] ^ yb[k+14] ^ yb[k+15];
        return {msb, lsb};
    endfunction

    function automatic int satNeg(input int v);
        return (-v > MAXV) ? MAXV : -v;
    endfunction

    function automatic exp_t modelOut(input int n, input int k, input int vi, input int vq);
        exp_t e;
        e.r   = modelR(n, k);
        e.sof = (k == 0);
        case (e.r)
            2'd0: begin e.ei = vi;         e.eq = vq;         end
            2'd1: begin e.ei = satNeg(vq); e.eq = vi;         end
            2'd2: begin e.ei = satNeg(vi); e.eq = satNeg(vq); end
            default: begin e.ei = vq;      e.eq = satNeg(vi); end
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input bit start, input int code, input bit valid,
                                 input int vi, input int vq, input bit ready, output bit accepted);
        @(negedge i_clk);
        i_start = start;
        i_code  = 18'(code);
        i_valid = valid;
        i_i     = DATA_W'(vi);
        i_q     = DATA_W'(vq);
        i_ready = ready;
        #4;
        accepted = 1'b0;
        if (i_reset) begin
            expQ.delete();
        end else if (start) begin
            expQ.delete();
            curCode = code;
            symIdx  = 0;
        end else if (valid && o_ready) begin
            accepted = 1'b1;
            expQ.push_back(modelOut(curCode, symIdx, vi, vq));
            symIdx = (symIdx + 1) % FRAME_LEN;
        end
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        #4 expQ.delete();
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic clearLogs();
        obsR.delete();
        obsSof.delete();
        obsI.delete();
        obsQ.delete();
    endtask

    task automatic feedConst(input int count, input int vi, input int vq);
        int sent = 0;
        int cyc  = 0;
        bit acc;
        while (obsR.size() < count && cyc < 200) begin
            applyStimulus(1'b0, 0, (sent < count), vi, vq, 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        checkOutput("feed_count", 32'(obsR.size()), 32'(count));
    endtask

    initial begin : monitor
        exp_t        e;
        logic [19:0] heldVal = '0;
        bit          holdPending = 1'b0;
        forever begin
            @(negedge i_clk);
            #3;
            if (holdPending) begin
                checkOutput("bp_hold", 32'({o_valid, o_i, o_q, o_r, o_sof}), 32'(heldVal));
            end
            if (o_valid && !i_ready && !i_reset && !i_start) begin
                holdPending = 1'b1;
                heldVal     = {o_valid, o_i, o_q, o_r, o_sof};
                checkOutput("bp_ready_low", 32'(o_ready), 32'd0);
            end else begin
                holdPending = 1'b0;
            end
            if (o_valid && i_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 32'(expQ.size()), 32'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("output", 32'({o_i, o_q, o_r, o_sof}),
                                32'({DATA_W'(e.ei), DATA_W'(e.eq), e.r, e.sof}));
                end
                obsR.push_back(o_r);
                obsSof.push_back(o_sof);
                obsI.push_back(int'($signed(o_i)));
                obsQ.push_back(int'($signed(o_q)));
            end
        end
    end

    initial begin : stimulus
        bit         acc;
        int         sent;
        int         cyc;
        int         busyCnt;
        int         readyAt;
        int         readyHigh;
        logic [1:0] refR[8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};

        for (int j = 0; j < 18; j++) begin
            xb[j] = (j == 0);
            yb[j] = 1'b1;
        end
        for (int k = 18; k < MODEL_LEN; k++) begin
            xb[k] = xb[k-11] ^ xb[k-18];
            yb[k] = yb[k-8] ^ yb[k-11] ^ yb[k-13] ^ yb[k-18];
        end

        // Reset values
        repeat (3) @(negedge i_clk);
        #4;
        checkOutput("reset_state", 32'({o_valid, o_ready, o_busy, o_sof, o_r, o_i, o_q}), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // n=0, constant (10,20) across two frames
        $display("[TB] n=0 two-frame sequence");
        applyStimulus(1'b1, 0, 1'b0, 0, 0, 1'b1, acc);
        clearLogs();
        feedConst(8, 10, 20);
        if (obsR.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput($sformatf("t1_r%0d", k), 32'(obsR[k]), 32'(refR[k]));
                checkOutput($sformatf("t1_sof%0d", k), 32'(obsSof[k]), 32'(k % 4 == 0));
            end
            checkOutput("t1_rot1", 32'({obsI[1], obsQ[1]}), 32'({-20, 10}));
        end

        // n=1 seek timing
        $display("[TB] n=1 seek timing");
        applyStimulus(1'b1, 1, 1'b0, 0, 0, 1'b1, acc);
        busyCnt = 0;
        readyAt = -1;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
            if (o_busy) busyCnt++;
            if (o_ready && readyAt < 0) readyAt = c;
        end
        checkOutput("n1_busy_cycles", 32'(busyCnt), 32'd2);
        checkOutput("n1_ready_at", 32'(readyAt), 32'd3);
        clearLogs();
        feedConst(1, 5, -7);
        if (obsR.size() >= 1) checkOutput("n1_first_r", 32'(obsR[0]), 32'd1);

        // Saturating negation on the R=1 symbol
        $display("[TB] saturation");
        applyStimulus(1'b1, 0, 1'b0, 0, 0, 1'b1, acc);
        clearLogs();
        sent = 0;
        cyc  = 0;
        while (obsR.size() < 2 && cyc < 50) begin
            if (sent == 0)      applyStimulus(1'b0, 0, 1'b1, 1, 2, 1'b1, acc);
            else if (sent == 1) applyStimulus(1'b0, 0, 1'b1, 0, -128, 1'b1, acc);
            else                applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        checkOutput("sat_count", 32'(obsR.size()), 32'd2);
        if (obsR.size() >= 2) checkOutput("sat_value", 32'({obsI[1], obsQ[1]}), 32'({127, 0}));

        // Backpressure: five stalled cycles after the first output
        $display("[TB] backpressure");
        applyStimulus(1'b1, 0, 1'b0, 0, 0, 1'b1, acc);
        clearLogs();
        sent = 0;
        cyc  = 0;
        do begin
            applyStimulus(1'b0, 0, 1'b1, 10, 20, 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end while (!o_valid && cyc < 20);
        checkOutput("bp_first_valid", 32'(o_valid), 32'd1);
        repeat (5) begin
            applyStimulus(1'b0, 0, 1'b1, 10, 20, 1'b0, acc);
            checkOutput("bp_stall_ready", 32'(o_ready), 32'd0);
        end
        cyc = 0;
        while (obsR.size() < 4 && cyc < 50) begin
            applyStimulus(1'b0, 0, (sent < 4), 10, 20, 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        checkOutput("bp_count", 32'(obsR.size()), 32'd4);
        if (obsR.size() >= 4) begin
            checkOutput("bp_seq", 32'({obsR[0], obsR[1], obsR[2], obsR[3]}), 32'(8'b00_01_01_01));
        end

        // Restart mid-frame while a symbol is offered
        $display("[TB] mid-frame restart");
        applyStimulus(1'b1, 0, 1'b0, 0, 0, 1'b1, acc);
        clearLogs();
        feedConst(2, 10, 20);
        applyStimulus(1'b1, 0, 1'b1, 30, 40, 1'b1, acc);
        checkOutput("start_blocks_ready", 32'(o_ready), 32'd0);
        clearLogs();
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
        checkOutput("start_drops_valid", 32'(o_valid), 32'd0);
        feedConst(1, 30, 40);
        if (obsR.size() >= 1) checkOutput("restart_first", 32'({obsR[0], obsSof[0]}), 32'({2'd0, 1'b1}));

        // Randomised traffic, codes, restarts and backpressure
        $display("[TB] random traffic");
        for (int it = 0; it < 6; it++) begin
            applyStimulus(1'b1, int'($urandom_range(0, 300)), 1'b0, 0, 0, 1'b1, acc);
            for (int c = 0; c < 150; c++) begin
                applyStimulus(($urandom_range(0, 59) == 0), int'($urandom_range(0, 300)),
                              ($urandom_range(0, 3) != 0),
                              int'($urandom_range(0, 255)) - 128,
                              int'($urandom_range(0, 255)) - 128,
                              ($urandom_range(0, 3) != 0), acc);
            end
            repeat (3) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
        end

        // Reset during a long seek
        $display("[TB] reset during seek");
        applyStimulus(1'b1, 1000, 1'b0, 0, 0, 1'b1, acc);
        repeat (10) applyStimulus(1'b0, 0, 1'b1, 1, 1, 1'b1, acc);
        checkOutput("seek_busy", 32'(o_busy), 32'd1);
        doReset();
        #4;
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        readyHigh = 0;
        repeat (20) begin
            applyStimulus(1'b0, 0, 1'b1, 1, 1, 1'b1, acc);
            if (o_ready) readyHigh++;
        end
        checkOutput("rst_idle_ready", 32'(readyHigh), 32'd0);
        applyStimulus(1'b1, 2, 1'b0, 0, 0, 1'b1, acc);
        clearLogs();
        feedConst(3, -100, 77);

        repeat (3) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1, acc);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
